// File: rtl/alu_pkg.sv
// Shared ALU encodings, flag positions and the mul/div sequencer state type.
package alu_pkg;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } seq_state_t;

endpackage

// File: rtl/alu.sv
// 32-bit execute-stage ALU: add/sub/and/or with {N,Z,C,V} flags; C is carry-out (no borrow on sub).
module alu
   import alu_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [1:0]  ctrl,
   output logic [31:0] result,
   output logic [3:0]  flags
);

   logic [32:0] w_sum;
   logic [31:0] w_b_eff;
   logic        w_is_arith;
   logic        w_ovf;

   assign w_b_eff    = (ctrl == ALU_SUB) ? ~b : b;
   assign w_sum      = {1'b0, a} + {1'b0, w_b_eff} + {32'd0, (ctrl == ALU_SUB)};
   assign w_is_arith = (ctrl == ALU_ADD) || (ctrl == ALU_SUB);
   assign w_ovf      = w_is_arith && (a[31] == w_b_eff[31]) && (w_sum[31] != a[31]);

   always_comb begin
      result = 32'd0;
      case (ctrl)
         ALU_ADD, ALU_SUB: result = w_sum[31:0];
         ALU_AND:          result = a & b;
         ALU_ORR:          result = a | b;
         default:          result = 32'd0;
      endcase
   end

   always_comb begin
      flags         = 4'd0;
      flags[FLAG_N] = result[31];
      flags[FLAG_Z] = (result == 32'd0);
      flags[FLAG_C] = w_is_arith & w_sum[32];
      flags[FLAG_V] = w_ovf;
   end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle MUL / UDIV sequencer that borrows the shared ALU for one add or subtract per cycle.
//   state  | meaning
//   S_IDLE | ALU released to execute stage, waiting for start
//   S_RUN  | 32 shift-add (MUL) or restoring-divide (UDIV) iterations
//   S_DONE | one-cycle done pulse, result/remainder valid
module alu_muldiv_seq
   import alu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              op,
   input  logic [DATA_W-1:0] opa,
   input  logic [DATA_W-1:0] opb,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic [DATA_W-1:0] remainder,
   output logic              div_by_zero,
   output logic [1:0]        alu_ctrl,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [3:0]        alu_flags
);

   seq_state_t        r_state;
   seq_state_t        w_state_nxt;
   logic              r_op;
   logic [DATA_W-1:0] r_acc;
   logic [DATA_W-1:0] r_mcand;
   logic [DATA_W-1:0] r_mplier;
   logic [DATA_W-1:0] r_result;
   logic [DATA_W-1:0] r_remainder;
   logic              r_dbz;
   logic [CNT_W-1:0]  r_cnt;

   logic              w_accept;
   logic              w_dbz_req;
   logic              w_last;
   logic              w_qbit;
   logic [DATA_W-1:0] w_rs;
   logic [DATA_W-1:0] w_acc_nxt;
   logic [DATA_W-1:0] w_mcand_nxt;
   logic [DATA_W-1:0] w_mplier_nxt;

   // r_acc doubles as partial product / partial remainder; r_mplier as multiplier / quotient.
   assign w_accept  = (r_state == S_IDLE) && start;
   assign w_dbz_req = op && (opb == '0);
   assign w_last    = (r_cnt == CNT_W'(DATA_W - 1));
   assign w_rs      = {r_acc[DATA_W-2:0], r_mplier[DATA_W-1]};
   // A set R[31] means the shifted remainder is 33 bits wide and always exceeds the divisor.
   assign w_qbit    = r_acc[DATA_W-1] | alu_flags[FLAG_C];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = w_dbz_req ? S_DONE : S_RUN;
         S_RUN:   if (w_last) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      alu_ctrl = ALU_ADD;
      alu_a    = '0;
      alu_b    = '0;
      if (r_state == S_RUN) begin
         alu_ctrl = r_op ? ALU_SUB : ALU_ADD;
         alu_a    = r_op ? w_rs : r_acc;
         alu_b    = r_mcand;
      end
   end

   always_comb begin
      w_acc_nxt    = r_acc;
      w_mcand_nxt  = r_mcand;
      w_mplier_nxt = r_mplier;
      if (r_op) begin
         w_acc_nxt    = w_qbit ? alu_result : w_rs;
         w_mplier_nxt = {r_mplier[DATA_W-2:0], w_qbit};
      end else begin
         w_acc_nxt    = r_mplier[0] ? alu_result : r_acc;
         w_mcand_nxt  = r_mcand << 1;
         w_mplier_nxt = r_mplier >> 1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_op        <= 1'b0;
         r_acc       <= '0;
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_result    <= '0;
         r_remainder <= '0;
         r_dbz       <= 1'b0;
         r_cnt       <= '0;
      end else if (w_accept) begin
         r_op     <= op;
         r_acc    <= '0;
         r_mcand  <= op ? opb : opa;
         r_mplier <= op ? opa : opb;
         r_cnt    <= '0;
         r_dbz    <= w_dbz_req;
         if (w_dbz_req) begin
            r_result    <= '1;
            r_remainder <= opa;
         end
      end else if (r_state == S_RUN) begin
         r_acc    <= w_acc_nxt;
         r_mcand  <= w_mcand_nxt;
         r_mplier <= w_mplier_nxt;
         r_cnt    <= r_cnt + CNT_W'(1);
         if (w_last) begin
            r_result    <= r_op ? w_mplier_nxt : w_acc_nxt;
            r_remainder <= r_op ? w_acc_nxt : '0;
         end
      end
   end

   assign busy        = (r_state != S_IDLE);
   assign done        = (r_state == S_DONE);
   assign result      = r_result;
   assign remainder   = r_remainder;
   assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq wired to the real ALU; expectations from plain * / % arithmetic.
module tb_alu_muldiv_seq;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        op = 1'b0;
   logic [31:0] opa = '0;
   logic [31:0] opb = '0;
   logic        busy, done, div_by_zero;
   logic [31:0] result, remainder, alu_a, alu_b, alu_result;
   logic [1:0]  alu_ctrl;
   logic [3:0]  alu_flags;

   alu u_alu (
      .a      (alu_a),
      .b      (alu_b),
      .ctrl   (alu_ctrl),
      .result (alu_result),
      .flags  (alu_flags)
   );

   alu_muldiv_seq #(.DATA_W(32), .CNT_W(5)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .opa         (opa),
      .opb         (opb),
      .busy        (busy),
      .done        (done),
      .result      (result),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .alu_ctrl    (alu_ctrl),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_result  (alu_result),
      .alu_flags   (alu_flags)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [31:0] res;
      logic [31:0] rem;
      logic        dbz;
      int          due;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse retires the oldest outstanding expectation.
   always @(negedge clk) begin
      if (reset && done === 1'b1) begin
         exp_t e;
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
         end else begin
            e = sb.pop_front();
            check("result", result, e.res);
            check("remainder", remainder, e.rem);
            check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
            check("latency", cyc, e.due);
         end
      end
   end

   // Issues one operation at a negedge with busy low; optional ignored start at
   // cycle inject_at and reset abort at cycle abort_at (0 disables either).
   task automatic run_op(input logic op_i, input logic [31:0] a, input logic [31:0] b,
                         input int inject_at, input int abort_at);
      exp_t        e;
      logic [63:0] prod;
      int          lat;
      if (op_i && b == 32'd0) begin
         e.res = 32'hFFFF_FFFF; e.rem = a; e.dbz = 1'b1; lat = 1;
      end else if (op_i) begin
         e.res = a / b; e.rem = a % b; e.dbz = 1'b0; lat = 33;
      end else begin
         prod = {32'd0, a} * {32'd0, b};
         e.res = prod[31:0]; e.rem = 32'd0; e.dbz = 1'b0; lat = 33;
      end
      e.due = cyc + lat;
      start = 1'b1; op = op_i; opa = a; opb = b;
      sb.push_back(e);
      for (int rel = 1; rel <= lat; rel++) begin
         @(negedge clk);
         start = (rel == inject_at);
         if (rel == inject_at) begin
            op = 1'b1; opa = $urandom; opb = 32'd0;
         end
         if (rel == abort_at) begin
            reset = 1'b0;
            start = 1'b0;
            #1;
            check("abort_busy", {31'd0, busy}, 32'd0);
            check("abort_done", {31'd0, done}, 32'd0);
            check("abort_result", result, 32'd0);
            check("abort_remainder", remainder, 32'd0);
            check("abort_dbz", {31'd0, div_by_zero}, 32'd0);
            sb.delete();
            repeat (2) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            return;
         end
         check("busy", {31'd0, busy}, 32'd1);
      end
      @(negedge clk);
      start = 1'b0;
      check("busy_clear", {31'd0, busy}, 32'd0);
      check("alu_a_idle", alu_a, 32'd0);
      check("alu_b_idle", alu_b, 32'd0);
      check("alu_ctrl_idle", {30'd0, alu_ctrl}, {30'd0, ALU_ADD});
      if (sb.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL missing_done: got %0d pending expected 0 pending", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      logic        r_op;
      logic [31:0] ra, rb;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_remainder", remainder, 32'd0);
      check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      run_op(1'b0, 32'd7, 32'd6, 0, 0);
      run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
      run_op(1'b0, 32'h0001_0000, 32'h0001_0000, 0, 0);
      run_op(1'b0, 32'd0, 32'h1234_5678, 0, 0);
      run_op(1'b1, 32'd100, 32'd7, 0, 0);
      run_op(1'b1, 32'hFFFF_FFFF, 32'd1, 0, 0);
      run_op(1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 0, 0);
      run_op(1'b1, 32'd5, 32'd0, 0, 0);
      run_op(1'b1, 32'd3, 32'd9, 0, 0);
      run_op(1'b0, 32'd123, 32'd456, 10, 0);
      run_op(1'b0, 32'd9, 32'd9, 0, 15);
      run_op(1'b1, 32'd5, 32'd0, 0, 0);
      run_op(1'b0, 32'd7, 32'd6, 0, 0);

      for (int i = 0; i < 40; i++) begin
         r_op = 1'($urandom_range(0, 1));
         ra = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 255));
         rb = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 255));
         if (r_op && $urandom_range(0, 7) == 0) rb = 32'd0;
         run_op(r_op, ra, rb, 0, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
